// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the iteration-counter width rule.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must hold values 0..WIDTH inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/lead_zero_count.sv
// Combinational leading-zero counter; returns WIDTH when the input is zero.
module lead_zero_count
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  // NOTE: the default assignment before the loop keeps this purely
  // combinational; without it a zero input would infer a latch.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, with
// leading zeros of the dividend skipped and a start/busy/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    lz;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH-1:0] r_next, q_next;

  lead_zero_count #(.WIDTH(WIDTH), .CW(CW)) u_lzc (
    .value (dividend),
    .count (lz)
  );

  // Trial subtraction one bit wider than the operands; the top bit is the borrow.
  assign trial     = {r_q, q_q[WIDTH-1]} - {1'b0, d_q};
  assign no_borrow = ~trial[WIDTH];
  assign r_next    = no_borrow ? trial[WIDTH-1:0] : {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign q_next    = {q_q[WIDTH-2:0], no_borrow};

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0 || dividend == '0) state_next = DONE;
          else                                 state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_q == CW'(1)) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: working registers are reset along with the outputs so an aborted
  // division leaves no stale partial remainder or quotient behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            d_q   <= divisor;
            r_q   <= '0;
            q_q   <= dividend << lz;
            cnt_q <= CW'(WIDTH) - lz;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else if (dividend == '0) begin
              quotient    <= '0;
              remainder   <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          r_q   <= r_next;
          q_q   <= q_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: a reference model pushes expected results
// and a monitor pops and compares them on every done pulse.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   assertions = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   done_count = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: plain integer division; latency counts significant dividend bits.
  function automatic exp_t model(input int a, input int b, input int c0);
    exp_t e;
    int   bits = 0;
    while ((a >> bits) != 0) bits++;
    if (b == 0) begin
      e.q = W'((1 << W) - 1); e.r = W'(a); e.dbz = 1'b1; e.cyc = c0 + 1;
    end else begin
      e.q = W'(a / b); e.r = W'(a % b); e.dbz = 1'b0;
      e.cyc = c0 + ((a == 0) ? 1 : bits + 1);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_count++;
      if (sb.size() == 0) begin
        assertions++;
        failures++;
        $display("FAIL spurious_done: done seen at cycle %0d with no request outstanding", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient",    quotient,    e.q);
        check("remainder",   remainder,   e.r);
        check("div_by_zero", div_by_zero, e.dbz);
        check("done_cycle",  cyc,         e.cyc);
        check("busy_at_done", busy,       1);
      end
    end
  end

  // Issue one division, optionally pulsing a second start while busy.
  task automatic run_div(input int a, input int b, input bit inject);
    exp_t e;
    int   n  = 0;
    int   d0 = done_count;
    @(negedge clk);
    start = 1'b1; dividend = W'(a); divisor = W'(b);
    e = model(a, b, cyc);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    while (busy && n < 40) begin
      n++;
      if (inject && n == 2) begin
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", n, e.cyc - (cyc - n - 1));
    check("done_pulses", done_count - d0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("rst_busy",      busy,        0);
    check("rst_done",      done,        0);
    check("rst_quotient",  quotient,    0);
    check("rst_remainder", remainder,   0);
    check("rst_dbz",       div_by_zero, 0);
    rst_n = 1'b1;

    run_div(13, 3, 1'b0);
    run_div(2, 3, 1'b0);
    run_div(15, 1, 1'b0);
    run_div(7, 0, 1'b0);
    run_div(9, 4, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_quotient",  quotient,  2);
    check("hold_remainder", remainder, 1);
    run_div(0, 5, 1'b0);
    run_div(13, 3, 1'b1);
    repeat (2) @(negedge clk);
    check("ignored_start_q", quotient,  4);
    check("ignored_start_r", remainder, 1);

    // Abort a division with reset in cycle 2.
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy",      busy,      0);
    check("abort_done",      done,      0);
    check("abort_quotient",  quotient,  0);
    check("abort_remainder", remainder, 0);
    repeat (8) @(negedge clk);
    run_div(13, 3, 1'b0);

    for (int k = 0; k < 20; k++) run_div(int'($urandom_range(15)), int'($urandom_range(15)), 1'b0);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) run_div(a, b, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
